switch_side_rr: RTL and testbench
=================================

SWITCH_SIDE_RR -- requirements
Module: switch_side_rr

Interface
REQ-001 Parameter N_PORT, default 4: number of input ports and destination devices; power of two, 2..16.
REQ-002 Parameter DW, default 8: data width in bits.
REQ-003 Parameter DEPTH, default 4: entries per input FIFO; power of two, at least 2.
REQ-004 Localparam AW = clog2(N_PORT): destination address width.
REQ-005 clk_i  in  1  sole clock; all logic is on its rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-low.
REQ-007 in_valid_i  in  N_PORT  per-port word valid.
REQ-008 in_dat_i  in  N_PORT*DW  per-port data; port p occupies bits [p*DW +: DW].
REQ-009 in_adr_i  in  N_PORT*AW  per-port destination address; port p occupies bits [p*AW +: AW].
REQ-010 in_ready_o  out  N_PORT  per-port accept; asserted when that port's FIFO is not full.
REQ-011 int_full_i  in  N_PORT  per-destination full flag from the far side.
REQ-012 int_dat_o  out  DW  registered data to the far side.
REQ-013 int_wen_o  out  N_PORT  registered one-hot write enable, indexed by destination.
REQ-014 occ_o  out  N_PORT  per-port FIFO non-empty flag, for status.

Function
REQ-015 A word is accepted on port p in any cycle where in_valid_i[p] & in_ready_o[p]; the pair {adr, dat} is pushed into FIFO p.
REQ-016 in_ready_o[p] shall be a registered function of occupancy: it deasserts in the cycle after the FIFO holds DEPTH entries.
REQ-017 A port is eligible when its FIFO is non-empty and int_full_i[head adr] = 0.
REQ-018 Round-robin arbitration: search starts at rr_ptr+1 modulo N_PORT; the first eligible port is granted; at most one grant per cycle.
REQ-019 rr_ptr updates to the granted index only on a grant; with no eligible port, rr_ptr holds.
REQ-020 A grant pops the head of the granted FIFO in the same cycle.
REQ-021 In the cycle after a grant: int_wen_o = one-hot(head adr) and int_dat_o = head dat. Otherwise int_wen_o = 0 and int_dat_o holds its last value.
REQ-022 Latency from acceptance to int_wen_o is exactly 2 cycles when the path is uncontended and the destination is not full.
REQ-023 int_full_i is sampled combinationally in the grant cycle. The far side shall assert full with at least one free entry remaining to absorb the in-flight word.
REQ-024 Simultaneous push and pop on one FIFO leaves the count unchanged. A push when full or a pop when empty cannot occur by construction.
REQ-025 FIFO read and write pointers are AW_F = clog2(DEPTH) bits wide and wrap modulo DEPTH; the count is AW_F+1 bits.
REQ-026 Word order per port is preserved; no word is dropped or duplicated.

Reset
REQ-027 While rst_i = 0 at a clock edge, the block shall clear: all FIFO pointers and counts to 0, rr_ptr to N_PORT-1 (so port 0 has first priority), int_wen_o to 0, int_dat_o to 0, occ_o to 0, and in_ready_o to 0.
REQ-028 in_ready_o rises in the first cycle after rst_i returns to 1.
REQ-029 Reset asserted mid-transfer discards all buffered words and any pending int_wen_o.

Configuration
REQ-030 Macro SWITCH_SIDE_LOCK_EN, when defined, adds the input in_last_i (N_PORT bits), which is stored with each word.
REQ-031 With SWITCH_SIDE_LOCK_EN: once a port is granted a word with last = 0, only that port is eligible until its word with last = 1 is granted. The lock persists while that port is empty or its destination is full.
REQ-032 Without SWITCH_SIDE_LOCK_EN: in_last_i is absent and every word is arbitrated independently.

Structure
REQ-033 Package switch_pkg shall hold the default parameters and the clog2 function.
REQ-034 One sub-module, side_fifo (a DW+AW-bit wide synchronous FIFO with count, full and empty), shall be instantiated N_PORT times. Arbitration and the output register stay in switch_side_rr.

Verification
REQ-035 After reset, push port 0 data 8'hA5 to adr 2 at T -> int_wen_o = 4'b0100 and int_dat_o = 8'hA5 at T+2, for one cycle only.
REQ-036 All 4 ports continuously valid, each targeting adr 1, int_full_i = 0 -> grants follow the order 0,1,2,3,0,... with exactly one int_wen_o pulse per cycle.
REQ-037 Push 5 words to port 1 with the grant blocked by int_full_i[3] = 1 (adr 3) -> in_ready_o[1] deasserts after the 4th word. On releasing full, the 4 words emerge in order.
REQ-038 Ports 0 and 2 pending, port 0's destination full -> port 2 is granted and port 0 is not blocked permanently.
REQ-039 Assert rst_i = 0 with 3 words buffered -> on release, occ_o = 0 and no int_wen_o pulse appears.
REQ-040 With SWITCH_SIDE_LOCK_EN: a 3-word packet on port 3 interleaved with traffic on port 0 -> the port 3 words emerge contiguously.

Source files
------------

// File: rtl/switch_side_rr_pkg.sv
// Shared defaults and helpers for the switch side round-robin block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package switch_pkg;

  localparam int N_PORT_DEF = 4;
  localparam int DW_DEF     = 8;
  localparam int DEPTH_DEF  = 4;

  // Ceiling log2; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/switch_side_rr_if.sv
// Bus bundle between the input ports / far side and switch_side_rr.
// Latency: n/a (wiring only); in_last_i exists only with SWITCH_SIDE_LOCK_EN.
// Backpressure: in_ready_o per port, int_full_i per destination.
interface switch_side_rr_if
  import switch_pkg::*;
#(
  parameter int N_PORT = N_PORT_DEF,
  parameter int DW     = DW_DEF,
  parameter int AW     = clog2(N_PORT)
);
  logic [N_PORT-1:0]    in_valid_i;
  logic [N_PORT*DW-1:0] in_dat_i;
  logic [N_PORT*AW-1:0] in_adr_i;
  logic [N_PORT-1:0]    in_ready_o;
  logic [N_PORT-1:0]    int_full_i;
  logic [DW-1:0]        int_dat_o;
  logic [N_PORT-1:0]    int_wen_o;
  logic [N_PORT-1:0]    occ_o;
`ifdef SWITCH_SIDE_LOCK_EN
  logic [N_PORT-1:0]    in_last_i;

  modport master (output in_valid_i, in_dat_i, in_adr_i, in_last_i, int_full_i,
                  input  in_ready_o, int_dat_o, int_wen_o, occ_o);
  modport slave  (input  in_valid_i, in_dat_i, in_adr_i, in_last_i, int_full_i,
                  output in_ready_o, int_dat_o, int_wen_o, occ_o);
`else
  modport master (output in_valid_i, in_dat_i, in_adr_i, int_full_i,
                  input  in_ready_o, int_dat_o, int_wen_o, occ_o);
  modport slave  (input  in_valid_i, in_dat_i, in_adr_i, int_full_i,
                  output in_ready_o, int_dat_o, int_wen_o, occ_o);
`endif
endinterface

// File: rtl/switch_side_rr_fifo.sv
// Per-port synchronous FIFO with registered full flag and count.
// Latency: a pushed word is visible at rdat the cycle after the push.
// Backpressure: full is registered from the next count, so a push is never offered when full.
module side_fifo
  import switch_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdat,
  output logic [W-1:0] rdat,
  output logic         full,
  output logic         empty
);
  localparam int AW_F = clog2(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [AW_F-1:0] wr_ptr;
  logic [AW_F-1:0] rd_ptr;
  logic [AW_F:0]   count;
  logic [AW_F:0]   count_nxt;
  logic            full_q;

  // Occupancy after this cycle's push/pop; push+pop together leaves it unchanged.
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  // Pointers, count and full flag; full reads as set during reset so ready stays low.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_nxt;
      full_q <= (count_nxt == (AW_F+1)'(DEPTH));
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wdat;
  end

  assign rdat  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = full_q;

endmodule

// File: rtl/switch_side_rr.sv
// N_PORT input FIFOs arbitrated round-robin onto a registered one-hot write bus; SWITCH_SIDE_LOCK_EN adds packet lock.
// Latency: 2 cycles from acceptance to int_wen_o when uncontended and destination not full.
// Backpressure: in_ready_o drops when a port FIFO fills; int_full_i blocks ports whose head targets that destination.
module switch_side_rr
  import switch_pkg::*;
#(
  parameter int N_PORT = N_PORT_DEF,
  parameter int DW     = DW_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input logic             clk_i,
  input logic             rst_i,
  switch_side_rr_if.slave bus
);
  localparam int AW = clog2(N_PORT);
`ifdef SWITCH_SIDE_LOCK_EN
  localparam int W = DW + AW + 1;
`else
  localparam int W = DW + AW;
`endif

  logic [N_PORT-1:0] push;
  logic [N_PORT-1:0] pop;
  logic [N_PORT-1:0] full;
  logic [N_PORT-1:0] empty;
  logic [N_PORT-1:0] elig;
  logic [W-1:0]      wdat     [N_PORT];
  logic [W-1:0]      head     [N_PORT];
  logic [AW-1:0]     head_adr [N_PORT];
  logic [DW-1:0]     head_dat [N_PORT];
  logic              gnt_vld;
  logic [AW-1:0]     gnt_idx;
  logic [AW-1:0]     srch_idx;
  logic [AW-1:0]     rr_ptr;
  logic [N_PORT-1:0] wen_q;
  logic [DW-1:0]     dat_q;
`ifdef SWITCH_SIDE_LOCK_EN
  logic              head_last [N_PORT];
  logic              lock_q;
  logic [AW-1:0]     lock_port;
`endif

  for (genvar p = 0; p < N_PORT; p++) begin : g_port
    assign push[p] = bus.in_valid_i[p] & ~full[p];
`ifdef SWITCH_SIDE_LOCK_EN
    assign wdat[p]      = {bus.in_last_i[p], bus.in_adr_i[p*AW +: AW], bus.in_dat_i[p*DW +: DW]};
    assign head_last[p] = head[p][W-1];
`else
    assign wdat[p]      = {bus.in_adr_i[p*AW +: AW], bus.in_dat_i[p*DW +: DW]};
`endif
    assign head_dat[p] = head[p][DW-1:0];
    assign head_adr[p] = head[p][DW +: AW];
    assign pop[p]      = gnt_vld && (gnt_idx == AW'(p));

    side_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (push[p]),
      .pop   (pop[p]),
      .wdat  (wdat[p]),
      .rdat  (head[p]),
      .full  (full[p]),
      .empty (empty[p])
    );
  end

  // A port competes when it holds a word whose destination can take it (and owns the lock, if any).
  always_comb begin
    elig = '0;
    for (int p = 0; p < N_PORT; p++) begin
      elig[p] = ~empty[p] & ~bus.int_full_i[head_adr[p]];
`ifdef SWITCH_SIDE_LOCK_EN
      if (lock_q && (lock_port != AW'(p))) elig[p] = 1'b0;
`endif
    end
  end

  // Round-robin search starting just after the last granted port.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = rr_ptr;
    srch_idx = rr_ptr;
    for (int i = 1; i <= N_PORT; i++) begin
      srch_idx = rr_ptr + AW'(i);
      if (!gnt_vld && elig[srch_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = srch_idx;
      end
    end
  end

  // Output register and round-robin pointer; data holds when there is no grant.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wen_q  <= '0;
      dat_q  <= '0;
      rr_ptr <= AW'(N_PORT - 1);
    end else begin
      wen_q <= '0;
      if (gnt_vld) begin
        wen_q  <= N_PORT'(1) << head_adr[gnt_idx];
        dat_q  <= head_dat[gnt_idx];
        rr_ptr <= gnt_idx;
      end
    end
  end

`ifdef SWITCH_SIDE_LOCK_EN
  // Packet lock: a granted non-last word pins arbitration to its port until the last word goes.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lock_q    <= 1'b0;
      lock_port <= '0;
    end else if (gnt_vld) begin
      lock_q    <= ~head_last[gnt_idx];
      lock_port <= gnt_idx;
    end
  end
`endif

  assign bus.in_ready_o = ~full;
  assign bus.occ_o      = ~empty;
  assign bus.int_wen_o  = wen_q;
  assign bus.int_dat_o  = dat_q;

endmodule

// File: tb/tb_switch_side_rr.sv
// Directed self-checking bench for switch_side_rr (4 ports, 8-bit data, depth 4).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// The packet-lock scenario runs only when SWITCH_SIDE_LOCK_EN is defined.
module tb_switch_side_rr;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  switch_side_rr_if #(.N_PORT(4), .DW(8), .AW(2)) bus ();

  switch_side_rr #(.N_PORT(4), .DW(8), .DEPTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.in_valid_i = '0;
    bus.in_dat_i   = '0;
    bus.in_adr_i   = '0;
    bus.int_full_i = '0;
`ifdef SWITCH_SIDE_LOCK_EN
    bus.in_last_i  = '0;
`endif
  endtask

  task automatic do_reset;
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    tests_run++;
    if (bus.in_ready_o !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready: got %b expected 0000", bus.in_ready_o); end
    tests_run++;
    if (bus.occ_o !== 4'b0000) begin tests_failed++; $display("FAIL reset_occ: got %b expected 0000", bus.occ_o); end
    tests_run++;
    if (bus.int_wen_o !== 4'b0000) begin tests_failed++; $display("FAIL reset_wen: got %b expected 0000", bus.int_wen_o); end
    tests_run++;
    if (bus.int_dat_o !== 8'h00) begin tests_failed++; $display("FAIL reset_dat: got %h expected 00", bus.int_dat_o); end
    rst = 1'b1;
    tick();
    tests_run++;
    if (bus.in_ready_o !== 4'b1111) begin tests_failed++; $display("FAIL reset_release_ready: got %b expected 1111", bus.in_ready_o); end
  endtask

  task automatic test_single;
    bus.in_valid_i = 4'b0001;
    bus.in_dat_i   = 32'h0000_00A5;
    bus.in_adr_i   = 8'b0000_0010;
    tick();
    bus.in_valid_i = '0;
    tests_run++;
    if (bus.int_wen_o !== 4'b0000) begin tests_failed++; $display("FAIL single_t1_wen: got %b expected 0000", bus.int_wen_o); end
    tests_run++;
    if (bus.occ_o !== 4'b0001) begin tests_failed++; $display("FAIL single_t1_occ: got %b expected 0001", bus.occ_o); end
    tick();
    tests_run++;
    if (bus.int_wen_o !== 4'b0100) begin tests_failed++; $display("FAIL single_t2_wen: got %b expected 0100", bus.int_wen_o); end
    tests_run++;
    if (bus.int_dat_o !== 8'hA5) begin tests_failed++; $display("FAIL single_t2_dat: got %h expected a5", bus.int_dat_o); end
    tick();
    tests_run++;
    if (bus.int_wen_o !== 4'b0000) begin tests_failed++; $display("FAIL single_t3_wen: got %b expected 0000", bus.int_wen_o); end
    tests_run++;
    if (bus.int_dat_o !== 8'hA5) begin tests_failed++; $display("FAIL single_t3_dat_hold: got %h expected a5", bus.int_dat_o); end
  endtask

  task automatic test_round_robin;
    logic [7:0] exp_d [4];
    exp_d = '{8'h09, 8'h1A, 8'h2B, 8'h3C};
    do_reset();
    bus.in_valid_i = 4'b1111;
    bus.in_dat_i   = 32'h3C2B_1A09;
    bus.in_adr_i   = 8'b0101_0101;
    tick();
    tick();
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (bus.int_wen_o !== 4'b0010) begin tests_failed++; $display("FAIL rr_wen[%0d]: got %b expected 0010", k, bus.int_wen_o); end
      tests_run++;
      if (bus.int_dat_o !== exp_d[k % 4]) begin tests_failed++; $display("FAIL rr_dat[%0d]: got %h expected %h", k, bus.int_dat_o, exp_d[k % 4]); end
      tick();
    end
    bus.in_valid_i = '0;
  endtask

  task automatic test_full_block;
    logic [7:0] w;
    do_reset();
    bus.int_full_i = 4'b1000;
    bus.in_valid_i = 4'b0010;
    bus.in_adr_i   = 8'b0000_1100;
    for (int i = 0; i < 4; i++) begin
      w = 8'hC0 + 8'(i);
      bus.in_dat_i = {16'h0000, w, 8'h00};
      tests_run++;
      if (bus.in_ready_o[1] !== 1'b1) begin tests_failed++; $display("FAIL full_ready_word%0d: got %b expected 1", i, bus.in_ready_o[1]); end
      tick();
    end
    bus.in_dat_i = {16'h0000, 8'hC4, 8'h00};
    tests_run++;
    if (bus.in_ready_o[1] !== 1'b0) begin tests_failed++; $display("FAIL full_ready_after4: got %b expected 0", bus.in_ready_o[1]); end
    tests_run++;
    if (bus.int_wen_o !== 4'b0000) begin tests_failed++; $display("FAIL full_blocked_wen: got %b expected 0000", bus.int_wen_o); end
    tick();
    tests_run++;
    if (bus.in_ready_o[1] !== 1'b0) begin tests_failed++; $display("FAIL full_ready_held: got %b expected 0", bus.in_ready_o[1]); end
    bus.in_valid_i = '0;
    bus.int_full_i = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      w = 8'hC0 + 8'(i);
      tests_run++;
      if (bus.int_wen_o !== 4'b1000) begin tests_failed++; $display("FAIL full_drain_wen%0d: got %b expected 1000", i, bus.int_wen_o); end
      tests_run++;
      if (bus.int_dat_o !== w) begin tests_failed++; $display("FAIL full_drain_dat%0d: got %h expected %h", i, bus.int_dat_o, w); end
    end
    tick();
    tests_run++;
    if (bus.int_wen_o !== 4'b0000) begin tests_failed++; $display("FAIL full_drain_end_wen: got %b expected 0000", bus.int_wen_o); end
    tests_run++;
    if (bus.occ_o !== 4'b0000) begin tests_failed++; $display("FAIL full_drain_end_occ: got %b expected 0000", bus.occ_o); end
  endtask

  task automatic test_skip_full;
    do_reset();
    bus.int_full_i = 4'b0010;
    bus.in_valid_i = 4'b0101;
    bus.in_adr_i   = 8'b0011_0001;
    bus.in_dat_i   = 32'h00AA_0055;
    tick();
    bus.in_valid_i = '0;
    tick();
    tests_run++;
    if (bus.int_wen_o !== 4'b1000) begin tests_failed++; $display("FAIL skip_port2_wen: got %b expected 1000", bus.int_wen_o); end
    tests_run++;
    if (bus.int_dat_o !== 8'hAA) begin tests_failed++; $display("FAIL skip_port2_dat: got %h expected aa", bus.int_dat_o); end
    tests_run++;
    if (bus.occ_o !== 4'b0001) begin tests_failed++; $display("FAIL skip_port0_waiting: got %b expected 0001", bus.occ_o); end
    bus.int_full_i = '0;
    tick();
    tests_run++;
    if (bus.int_wen_o !== 4'b0010) begin tests_failed++; $display("FAIL skip_port0_wen: got %b expected 0010", bus.int_wen_o); end
    tests_run++;
    if (bus.int_dat_o !== 8'h55) begin tests_failed++; $display("FAIL skip_port0_dat: got %h expected 55", bus.int_dat_o); end
    tick();
    tests_run++;
    if (bus.occ_o !== 4'b0000) begin tests_failed++; $display("FAIL skip_end_occ: got %b expected 0000", bus.occ_o); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.int_full_i = 4'b0001;
    bus.in_valid_i = 4'b0001;
    bus.in_adr_i   = 8'b0000_0000;
    bus.in_dat_i   = 32'h0000_0077;
    tick();
    tick();
    tick();
    bus.in_valid_i = '0;
    tests_run++;
    if (bus.occ_o !== 4'b0001) begin tests_failed++; $display("FAIL midrst_buffered_occ: got %b expected 0001", bus.occ_o); end
    rst = 1'b0;
    bus.int_full_i = '0;
    tick();
    tests_run++;
    if (bus.int_wen_o !== 4'b0000) begin tests_failed++; $display("FAIL midrst_during_wen: got %b expected 0000", bus.int_wen_o); end
    rst = 1'b1;
    tick();
    tests_run++;
    if (bus.occ_o !== 4'b0000) begin tests_failed++; $display("FAIL midrst_occ: got %b expected 0000", bus.occ_o); end
    tests_run++;
    if (bus.in_ready_o !== 4'b1111) begin tests_failed++; $display("FAIL midrst_ready: got %b expected 1111", bus.in_ready_o); end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (bus.int_wen_o !== 4'b0000) begin tests_failed++; $display("FAIL midrst_wen[%0d]: got %b expected 0000", k, bus.int_wen_o); end
      tick();
    end
  endtask

`ifdef SWITCH_SIDE_LOCK_EN
  task automatic test_lock;
    logic [7:0] exp_d [7];
    logic [3:0] exp_w [7];
    exp_d = '{8'h00, 8'h30, 8'h31, 8'h32, 8'h01, 8'h02, 8'h03};
    exp_w = '{4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0010};
    do_reset();
    bus.in_adr_i = 8'b1000_0001;
    for (int c = 0; c < 9; c++) begin
      if (c < 3) begin
        bus.in_valid_i = 4'b1001;
        bus.in_dat_i   = {8'h30 + 8'(c), 16'h0000, 8'(c)};
        bus.in_last_i  = {(c == 2), 2'b00, 1'b1};
      end else if (c == 3) begin
        bus.in_valid_i = 4'b0001;
        bus.in_dat_i   = 32'h0000_0003;
        bus.in_last_i  = 4'b0001;
      end else begin
        bus.in_valid_i = '0;
      end
      if (c >= 2) begin
        tests_run++;
        if (bus.int_wen_o !== exp_w[c-2]) begin tests_failed++; $display("FAIL lock_wen[%0d]: got %b expected %b", c-2, bus.int_wen_o, exp_w[c-2]); end
        tests_run++;
        if (bus.int_dat_o !== exp_d[c-2]) begin tests_failed++; $display("FAIL lock_dat[%0d]: got %h expected %h", c-2, bus.int_dat_o, exp_d[c-2]); end
      end
      tick();
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_full_block();
    test_skip_full();
    test_reset_mid();
`ifdef SWITCH_SIDE_LOCK_EN
    test_lock();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
